udp_delay_line: RTL

UDP_DELAY_LINE -- requirements
Module: udp_delay_line

---
 rtl/udp_delay_line.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/udp_delay_line.sv
// ============================================================================
// Module  : udp_delay_line
// Brief   : Multi-channel programmable delay line (1..MAX_DEPTH ce cycles)
//           with FILL masking. Optional macro UDP_DELAY_LINE_OUTREG_EN adds
//           one extra output register stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int CH_NUM     = 2,
    parameter int MAX_DEPTH  = 16,
    localparam int AW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ce,
    input  logic [AW-1:0]                latency,
    input  logic [CH_NUM*DATA_WIDTH-1:0] din,
    input  logic                         din_vld,
    output logic [CH_NUM*DATA_WIDTH-1:0] dout,
    output logic                         dout_vld,
    output logic                         busy
);

    localparam int            c_DW    = CH_NUM * DATA_WIDTH;
    localparam int            c_IW    = $clog2(MAX_DEPTH);
    localparam logic [AW-1:0] c_MAX_L = AW'(MAX_DEPTH);
    localparam logic [AW-1:0] c_ONE   = AW'(1);
    localparam logic [AW-1:0] c_WRAP  = AW'(MAX_DEPTH - 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    logic [c_DW:0]   r_mem [MAX_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_fill_cnt;
    logic [AW-1:0]   r_lat;
    state_t          r_state;
    logic [c_DW-1:0] r_dout;
    logic            r_dout_vld;

    logic [AW-1:0]   w_lat;
    logic            w_chg;
    state_t          w_state_nxt;
    logic [AW-1:0]   w_cnt_nxt;
    logic            w_load;
    logic [AW:0]     w_rd_sum;
    logic [c_IW-1:0] w_rd_idx;
    logic [c_IW-1:0] w_wr_idx;
    logic [c_DW:0]   w_rd_data;

    always_comb begin
        w_lat = latency;
        if (latency == '0) begin
            w_lat = c_ONE;
        end else if (latency > c_MAX_L) begin
            w_lat = c_MAX_L;
        end
    end

    assign w_chg = (w_lat != r_lat);

    // The sample taken L-1 ce cycles ago lives at wr_ptr-(L-1); L==1 bypasses
    // the buffer so the output register alone supplies the single cycle.
    always_comb begin
        w_rd_sum = {1'b0, r_wr_ptr} + (AW+1)'(MAX_DEPTH + 1) - {1'b0, w_lat};
        if (w_rd_sum >= (AW+1)'(MAX_DEPTH)) begin
            w_rd_sum = w_rd_sum - (AW+1)'(MAX_DEPTH);
        end
        w_rd_idx  = c_IW'(w_rd_sum);
        w_wr_idx  = c_IW'(r_wr_ptr);
        w_rd_data = (w_lat == c_ONE) ? {din_vld, din} : r_mem[w_rd_idx];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_fill_cnt;
        w_load      = 1'b0;
        if ((r_state == S_FILL) || w_chg) begin
            w_cnt_nxt = w_chg ? '0 : (r_fill_cnt + c_ONE);
            if (w_cnt_nxt >= (w_lat - c_ONE)) begin
                w_state_nxt = S_RUN;
                w_load      = 1'b1;
            end else begin
                w_state_nxt = S_FILL;
            end
        end else begin
            w_load = 1'b1;
        end
    end

    // Storage carries no reset; stale entries are hidden by FILL.
    always_ff @(posedge clk) begin
        if (ce) begin
            r_mem[w_wr_idx] <= {din_vld, din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_lat      <= c_ONE;
            r_state    <= S_FILL;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else if (ce) begin
            r_wr_ptr   <= (r_wr_ptr == c_WRAP) ? '0 : (r_wr_ptr + c_ONE);
            r_fill_cnt <= w_cnt_nxt;
            r_lat      <= w_lat;
            r_state    <= w_state_nxt;
            if (w_load) begin
                {r_dout_vld, r_dout} <= w_rd_data;
            end else begin
                r_dout_vld <= 1'b0;
            end
        end
    end

`ifdef UDP_DELAY_LINE_OUTREG_EN
    logic [c_DW-1:0] r_dout_q;
    logic            r_dout_vld_q;
    logic            r_fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_q     <= '0;
            r_dout_vld_q <= 1'b0;
            r_fill_q     <= 1'b1;
        end else if (ce) begin
            r_dout_q     <= r_dout;
            r_dout_vld_q <= r_dout_vld;
            r_fill_q     <= (r_state == S_FILL);
        end
    end

    assign dout     = r_dout_q;
    assign dout_vld = r_dout_vld_q;
    assign busy     = (r_state == S_FILL) | r_fill_q;
`else
    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign busy     = (r_state == S_FILL);
`endif

endmodule

`default_nettype wire
